// File: rtl/ds_dac_pkg.sv
// Shared constants for the multi-channel first-order delta-sigma DAC.
// Provides the sigma reset value and the offset-binary midscale as functions of WIDTH.
package ds_dac_pkg;

    // Sigma register reset value: 2**w, the centre of the sigma swing.
    function automatic int unsigned sigma_rst(input int unsigned w);
        return 32'd1 << w;
    endfunction

    // Offset-binary midscale: 2**(w-1).
    function automatic int unsigned midscale(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

endpackage

// File: rtl/ds_mod1.sv
// One first-order delta-sigma modulator channel: sigma register plus output flop.
// Ports: clk_i, rst_i (async high), target_i [WIDTH-1:0] level, dac_o 1-bit stream.
module ds_mod1
    import ds_dac_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] target_i,
    output logic             dac_o
);

    localparam logic [WIDTH+1:0] S_RST = (WIDTH+2)'(sigma_rst(WIDTH));

    logic [WIDTH+1:0] s_q;
    logic [WIDTH+1:0] s_d;
    logic [WIDTH+1:0] fb;
    logic             dac_q;

    // Feedback is {msb,msb,0..0}: adds -2**WIDTH (mod 2**(WIDTH+2)) when msb is set.
    assign fb  = {s_q[WIDTH+1], s_q[WIDTH+1], {WIDTH{1'b0}}};
    assign s_d = s_q + {2'b00, target_i} + fb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q   <= S_RST;
            dac_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            dac_q <= s_q[WIDTH+1];
        end
    end

    assign dac_o = dac_q;

endmodule

// File: rtl/ds_dac_multi.sv
// Multi-channel delta-sigma DAC: one-frame pending buffer, sample-period tick, mute ramp.
// Ports: Clk, Reset, SampleData/SampleValid/SampleReady frame handshake, Mute,
// DACout[CHANNELS] bitstreams, SampleTick period pulse, Underrun sticky flag.
module ds_dac_multi
    import ds_dac_pkg::*;
#(
    parameter int WIDTH    = 13,
    parameter int CHANNELS = 2,
    parameter int DIV      = 256
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] SampleData,
    input  logic                      SampleValid,
    output logic                      SampleReady,
    input  logic                      Mute,
    output logic [CHANNELS-1:0]       DACout,
    output logic                      SampleTick,
    output logic                      Underrun
);

    localparam int               CW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);
    localparam logic [WIDTH-1:0] MID     = WIDTH'(midscale(WIDTH));

    typedef logic [CHANNELS-1:0][WIDTH-1:0] frame_t;

    logic [CW-1:0] cnt_q,  cnt_d;
    frame_t        pend_q, pend_d;
    frame_t        act_q,  act_d;
    frame_t        tgt_q,  tgt_d;
    frame_t        goal;
    logic          full_q, full_d;
    logic          und_q,  und_d;
    logic          tick;
    logic          xfer;

    assign tick = (cnt_q == CNT_MAX);
    assign xfer = SampleValid && !full_q;

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        pend_d = xfer ? frame_t'(SampleData) : pend_q;
        // A transfer can only happen with pending empty, so it wins over the tick drain.
        full_d = full_q;
        if (tick) full_d = 1'b0;
        if (xfer) full_d = 1'b1;
        act_d  = (tick && full_q) ? pend_q : act_q;
        und_d  = und_q | (tick & ~full_q);
    end

    always_comb begin
        goal = '0;
        for (int k = 0; k < CHANNELS; k++)
            goal[k] = Mute ? MID : act_q[k];
    end

    // Target slews one LSB per tick toward its goal, so it can never overshoot.
    always_comb begin
        tgt_d = tgt_q;
        if (tick) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (tgt_q[k] < goal[k])
                    tgt_d[k] = tgt_q[k] + WIDTH'(1);
                else if (tgt_q[k] > goal[k])
                    tgt_d[k] = tgt_q[k] - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            pend_q <= '0;
            full_q <= 1'b0;
            und_q  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                act_q[k] <= MID;
                tgt_q[k] <= MID;
            end
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            full_q <= full_d;
            und_q  <= und_d;
            act_q  <= act_d;
            tgt_q  <= tgt_d;
        end
    end

    assign SampleReady = !full_q;
    assign SampleTick  = tick;
    assign Underrun    = und_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        ds_mod1 #(
            .WIDTH(WIDTH)
        ) u_mod (
            .clk_i   (Clk),
            .rst_i   (Reset),
            .target_i(tgt_q[k]),
            .dac_o   (DACout[k])
        );
    end

endmodule

// File: tb/tb_ds_dac_multi.sv
// Directed bench for ds_dac_multi: handshake/tick table, density windows,
// mute ramp and asynchronous reset in mid-transfer.
module tb_ds_dac_multi;

    localparam int W   = 13;
    localparam int CH  = 2;
    localparam int DV  = 4;
    localparam logic [W-1:0] MID = 13'd4096;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [CH*W-1:0]   SampleData;
    logic              SampleValid;
    logic              SampleReady;
    logic              Mute;
    logic [CH-1:0]     DACout;
    logic              SampleTick;
    logic              Underrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ds_dac_multi #(
        .WIDTH   (W),
        .CHANNELS(CH),
        .DIV     (DV)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SampleData (SampleData),
        .SampleValid(SampleValid),
        .SampleReady(SampleReady),
        .Mute       (Mute),
        .DACout     (DACout),
        .SampleTick (SampleTick),
        .Underrun   (Underrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic         vld;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         rdy;
        logic         tick;
        logic         und;
        logic [W-1:0] act0;
        logic [W-1:0] act1;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        SampleValid = 1'b0;
        SampleData  = '0;
        Mute        = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Returns at the negedge just after the next tick edge.
    task automatic wait_tick();
        int n = 0;
        while (!SampleTick && n < 4 * DV) begin
            @(negedge Clk);
            n++;
        end
        if (!SampleTick) chk("tick_timeout", 32'd0, 32'd1);
        @(negedge Clk);
    endtask

    initial begin
        int ones0;
        int ones1;
        logic [W-1:0] A0, A1, B0, B1, C0, C1;
        A0 = 13'd4100; A1 = 13'd200;
        B0 = 13'd300;  B1 = 13'd8000;
        C0 = 13'd1234; C1 = 13'd4096;

        //        vld d0  d1  rdy tick und act0 act1
        vt[0]  = '{1'b1, A0, A1, 1'b1, 1'b0, 1'b0, MID, MID};
        vt[1]  = '{1'b1, B0, B1, 1'b0, 1'b0, 1'b0, MID, MID};
        vt[2]  = '{1'b1, B0, B1, 1'b0, 1'b0, 1'b0, MID, MID};
        vt[3]  = '{1'b1, B0, B1, 1'b0, 1'b1, 1'b0, MID, MID};
        vt[4]  = '{1'b1, B0, B1, 1'b1, 1'b0, 1'b0, A0,  A1};
        vt[5]  = '{1'b0, 0,  0,  1'b0, 1'b0, 1'b0, A0,  A1};
        vt[6]  = '{1'b0, 0,  0,  1'b0, 1'b0, 1'b0, A0,  A1};
        vt[7]  = '{1'b0, 0,  0,  1'b0, 1'b1, 1'b0, A0,  A1};
        vt[8]  = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b0, B0,  B1};
        vt[9]  = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b0, B0,  B1};
        vt[10] = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b0, B0,  B1};
        vt[11] = '{1'b0, 0,  0,  1'b1, 1'b1, 1'b0, B0,  B1};
        vt[12] = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b1, B0,  B1};
        vt[13] = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b1, B0,  B1};
        vt[14] = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b1, B0,  B1};
        vt[15] = '{1'b1, C0, C1, 1'b1, 1'b1, 1'b1, B0,  B1};
        vt[16] = '{1'b0, 0,  0,  1'b0, 1'b0, 1'b1, B0,  B1};
        vt[17] = '{1'b0, 0,  0,  1'b0, 1'b0, 1'b1, B0,  B1};
        vt[18] = '{1'b0, 0,  0,  1'b0, 1'b0, 1'b1, B0,  B1};
        vt[19] = '{1'b0, 0,  0,  1'b0, 1'b1, 1'b1, B0,  B1};
        vt[20] = '{1'b0, 0,  0,  1'b1, 1'b0, 1'b1, C0,  C1};

        do_reset();
        chk("rst_dac", 32'(DACout), 32'd0);
        chk("rst_sigma0", 32'(dut.g_ch[0].u_mod.s_q), 32'd8192);
        chk("rst_tgt0", 32'(dut.tgt_q[0]), 32'(MID));

        // Handshake / tick table, one row per clock.
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge Clk);
            SampleValid = vt[i].vld;
            SampleData  = {vt[i].d1, vt[i].d0};
            chk($sformatf("ready[%0d]", i), 32'(SampleReady), 32'(vt[i].rdy));
            chk($sformatf("tick[%0d]", i), 32'(SampleTick), 32'(vt[i].tick));
            chk($sformatf("und[%0d]", i), 32'(Underrun), 32'(vt[i].und));
            chk($sformatf("act0[%0d]", i), 32'(dut.act_q[0]), 32'(vt[i].act0));
            chk($sformatf("act1[%0d]", i), 32'(dut.act_q[1]), 32'(vt[i].act1));
        end

        // Reset mid-transfer: frame latched, counter mid-period, underrun set.
        SampleValid = 1'b1;
        SampleData  = {13'd7, 13'd9};
        @(posedge Clk);
        #2;
        SampleValid = 1'b0;
        chk("pre_rst_ready", 32'(SampleReady), 32'd0);
        chk("pre_rst_und", 32'(Underrun), 32'd1);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(SampleReady), 32'd1);
        chk("mid_rst_tick", 32'(SampleTick), 32'd0);
        chk("mid_rst_und", 32'(Underrun), 32'd0);
        chk("mid_rst_dac", 32'(DACout), 32'd0);
        chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("mid_rst_act0", 32'(dut.act_q[0]), 32'(MID));
        chk("mid_rst_tgt1", 32'(dut.tgt_q[1]), 32'(MID));
        chk("mid_rst_sig0", 32'(dut.g_ch[0].u_mod.s_q), 32'd8192);
        chk("mid_rst_sig1", 32'(dut.g_ch[1].u_mod.s_q), 32'd8192);

        // No frames: underrun after first tick, midscale density.
        do_reset();
        chk("nf_und_c0", 32'(Underrun), 32'd0);
        repeat (3) @(negedge Clk);
        chk("nf_tick_c3", 32'(SampleTick), 32'd1);
        chk("nf_und_c3", 32'(Underrun), 32'd0);
        @(negedge Clk);
        chk("nf_und_c4", 32'(Underrun), 32'd1);
        repeat (12) @(negedge Clk);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 8192; i++) begin
            @(negedge Clk);
            ones0 += int'(DACout[0]);
            ones1 += int'(DACout[1]);
        end
        chk("mid_ones0", 32'(ones0), 32'd4096);
        chk("mid_ones1", 32'(ones1), 32'd4096);
        chk("nf_und_late", 32'(Underrun), 32'd1);

        // Full-scale extremes: ch0 ramps to 0, ch1 to 8191.
        do_reset();
        SampleValid = 1'b1;
        SampleData  = {13'd8191, 13'd0};
        @(negedge Clk);
        SampleValid = 1'b0;
        repeat (16500) @(negedge Clk);
        chk("ext_tgt0", 32'(dut.tgt_q[0]), 32'd0);
        chk("ext_tgt1", 32'(dut.tgt_q[1]), 32'd8191);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 8192; i++) begin
            @(negedge Clk);
            ones0 += int'(DACout[0]);
            ones1 += int'(DACout[1]);
        end
        chk("zero_ones0", 32'(ones0), 32'd0);
        chk("full_ones1", 32'(ones1), 32'd8191);

        // Mute ramp: ch0 4100 -> 4096 -> 4100, ch1 4092 -> 4096 -> 4092.
        do_reset();
        SampleValid = 1'b1;
        SampleData  = {13'd4092, 13'd4100};
        @(negedge Clk);
        SampleValid = 1'b0;
        repeat (40) @(negedge Clk);
        chk("pre_mute_t0", 32'(dut.tgt_q[0]), 32'd4100);
        chk("pre_mute_t1", 32'(dut.tgt_q[1]), 32'd4092);
        Mute = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_tick();
            chk($sformatf("mute_t0[%0d]", i), 32'(dut.tgt_q[0]),
                32'(i > 4 ? 4096 : 4100 - i));
            chk($sformatf("mute_t1[%0d]", i), 32'(dut.tgt_q[1]),
                32'(i > 4 ? 4096 : 4092 + i));
        end
        Mute = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wait_tick();
            chk($sformatf("unmute_t0[%0d]", i), 32'(dut.tgt_q[0]),
                32'(i > 4 ? 4100 : 4096 + i));
            chk($sformatf("unmute_t1[%0d]", i), 32'(dut.tgt_q[1]),
                32'(i > 4 ? 4092 : 4096 - i));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ds_dac_multi.md
DS_DAC_MULTI -- requirements
Module: ds_dac_multi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, meaning DAC sample width in bits (offset binary, midscale 2**(WIDTH-1)).
REQ-002 The block SHALL have parameter CHANNELS, default 2, meaning number of independent modulator channels.
REQ-003 The block SHALL have parameter DIV, default 256, meaning clocks per sample period (DIV >= 2).
REQ-004 The block SHALL have port Clk, input, 1, meaning the single clock; all logic is on posedge Clk.
REQ-005 The block SHALL have port Reset, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have port SampleData, input, CHANNELS*WIDTH, meaning one frame; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port SampleValid, input, 1, meaning SampleData holds a frame.
REQ-008 The block SHALL have port SampleReady, output, 1, meaning the pending buffer is empty and can accept a frame.
REQ-009 The block SHALL have port Mute, input, 1, meaning ramp all channels to midscale while high.
REQ-010 The block SHALL have port DACout, output, CHANNELS, meaning registered 1-bit modulator outputs for the external low-pass filters.
REQ-011 The block SHALL have port SampleTick, output, 1, meaning a one-clock pulse at each sample-period boundary.
REQ-012 The block SHALL have port Underrun, output, 1, meaning a sticky flag set when a tick finds no pending frame.

Function
REQ-013 A frame SHALL transfer when SampleValid and SampleReady are both high at a clock edge; SampleReady SHALL go low on the following cycle.
REQ-014 The pending buffer SHALL hold one frame; SampleValid while SampleReady is low SHALL be ignored and need not be held.
REQ-015 A tick counter SHALL count 0..DIV-1 and wrap; SampleTick SHALL be high in the cycle where the count equals DIV-1.
REQ-016 On a tick with pending full, the pending frame SHALL move to the active register on that edge, and SampleReady SHALL be high the next cycle.
REQ-017 On a tick with pending empty, the active register SHALL hold its value, and Underrun SHALL set.
REQ-018 Underrun SHALL clear only on Reset.
REQ-019 A transfer and a tick on the same edge SHALL place the incoming frame in pending; it SHALL become active at the next tick.
REQ-020 Mute SHALL be implemented as a per-channel target register; on each tick with Mute high, the target SHALL step 1 LSB toward 2**(WIDTH-1) and not overshoot.
REQ-021 On each tick with Mute low, the target SHALL step 1 LSB toward the active value; a step SHALL equal the remaining difference if that difference is 1.
REQ-022 Each channel SHALL be a first-order modulator with a WIDTH+2-bit sigma register S.
REQ-023 The modulator update SHALL be S <= S + target + ({S[msb],S[msb]} << WIDTH), computed modulo 2**(WIDTH+2).
REQ-024 DACout[k] SHALL be S[msb] registered; output latency from S SHALL be one clock.
REQ-025 The long-run density of DACout ones SHALL equal target/2**WIDTH.
REQ-026 All channels SHALL update every clock and SHALL share the tick.

Reset
REQ-027 On Reset, S SHALL be set to 2**WIDTH.
REQ-028 On Reset, DACout SHALL be set to 0.
REQ-029 On Reset, active and target SHALL be set to 2**(WIDTH-1), and pending SHALL be empty.
REQ-030 On Reset, the counter SHALL be 0, SampleReady SHALL be 1, SampleTick SHALL be 0 and Underrun SHALL be 0.
REQ-031 Reset asserted mid-frame or mid-ramp SHALL abandon all state immediately, with no partial update.

Structure
REQ-032 The reset constant for S and the midscale constant SHALL be defined as functions of WIDTH in a shared package ds_dac_pkg.
REQ-033 A single sub-module ds_mod1, parameterised by WIDTH, SHALL contain one sigma register and the DACout flop, and SHALL be instantiated CHANNELS times.
REQ-034 The handshake, tick and ramp logic SHALL reside in the top level.

Verification
REQ-035 With WIDTH=13, target held at 4096 for 8192 clocks, DACout[0] SHALL contain exactly 4096 ones.
REQ-036 With target=0, DACout SHALL be 0 on every cycle after settling; with target=8191, exactly 8191 ones SHALL occur per 8192 clocks.
REQ-037 Frames A and B sent back-to-back with DIV=4: A SHALL be accepted, B SHALL be stalled until the tick, and A and B SHALL become active at consecutive ticks.
REQ-038 With no frame supplied, Underrun SHALL be 1 after the first tick and remain 1 until Reset.
REQ-039 Mute asserted with active=4100 SHALL move the target 4100->4096 over 4 ticks; Mute released SHALL return it to 4100 over 4 ticks.
REQ-040 Reset asserted mid-transfer SHALL produce all REQ-027..030 values in the same cycle.
